// File: rtl/vliw_pkg.sv
// Shared definitions for the parametrised VLIW core: opcodes, slot field layout
// helpers and the Execute-stage state type.
package vliw_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MOV  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam int SLOT_W  = 32;
  localparam int EN_BIT  = 31;
  localparam int DEST_LO = 3;

  typedef enum logic {
    X_RUN    = 1'b0,
    MUL_WAIT = 1'b1
  } xstate_t;

  // Field positions inside a 32-bit slot, derived from the register-address width.
  function automatic int src1Lo(input int raw);
    return DEST_LO + raw;
  endfunction

  function automatic int src2Lo(input int raw);
    return DEST_LO + 2 * raw;
  endfunction

  function automatic int immLo(input int raw);
    return DEST_LO + 3 * raw;
  endfunction

  function automatic int immW(input int raw);
    return EN_BIT - immLo(raw);
  endfunction

endpackage

// File: rtl/vliw_slot_alu.sv
// One issue slot's ALU: computes the result for its own opcode and flags whether
// the opcode produces a register write at all.
module vliw_slot_alu
  import vliw_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] s1_i,
  input  logic [XLEN-1:0] s2_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] result_o,
  output logic            wr_en_o
);

  always_comb begin
    result_o = '0;
    wr_en_o  = 1'b1;
    case (op_i)
      OP_ADD:  result_o = s1_i + s2_i;
      OP_MUL:  result_o = s1_i * s2_i;
      OP_ADDI: result_o = s1_i + imm_i;
      OP_SUB:  result_o = s1_i - s2_i;
      OP_MOV:  result_o = imm_i;
      OP_AND:  result_o = s1_i & s2_i;
      OP_OR:   result_o = s1_i | s2_i;
      OP_NOP:  wr_en_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/vliw_core_param.sv
// N-slot VLIW core: Fetch and Decode registers feeding a combinational Execute stage
// over a shared register file, with a multi-cycle MUL stall and ordered write arbitration.
module vliw_core_param
  import vliw_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int XLEN      = 32,
  parameter int NREGS     = 8,
  parameter int MUL_LAT   = 3,
  parameter int R0_ZERO   = 1,
  localparam int RAW      = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [32*NUM_SLOTS-1:0]   in_bundle,
  output logic                      busy,
  output logic                      wr_conflict,
  output logic [31:0]               retired_cnt,
  input  logic [RAW-1:0]            dbg_addr,
  output logic [XLEN-1:0]           dbg_data
);

  localparam int S1_LO  = src1Lo(RAW);
  localparam int S2_LO  = src2Lo(RAW);
  localparam int IMM_LO = immLo(RAW);
  localparam int IMM_W  = immW(RAW);
  localparam int CW     = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  logic                    fValid_q;
  logic [32*NUM_SLOTS-1:0] fBundle_q;
  logic                    dValid_q;
  logic [2:0]              dOp_q   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    dEn_q;
  logic [RAW-1:0]          dDest_q [NUM_SLOTS];
  logic [RAW-1:0]          dSrc1_q [NUM_SLOTS];
  logic [RAW-1:0]          dSrc2_q [NUM_SLOTS];
  logic [XLEN-1:0]         dImm_q  [NUM_SLOTS];

  logic [2:0]              decOp   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    decEn;
  logic [RAW-1:0]          decDest [NUM_SLOTS];
  logic [RAW-1:0]          decSrc1 [NUM_SLOTS];
  logic [RAW-1:0]          decSrc2 [NUM_SLOTS];
  logic [XLEN-1:0]         decImm  [NUM_SLOTS];

  logic [XLEN-1:0]         rf_q    [NREGS];
  logic [XLEN-1:0]         rfRd    [NREGS];
  logic [XLEN-1:0]         aluResult [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    aluWe;
  logic [NUM_SLOTS-1:0]    slotWe;
  logic [NUM_SLOTS-1:0]    isMul;

  xstate_t                 state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:0]             retiredCnt_q;
  logic                    wrConflict_q;

  logic hasMul, mulStart, retire, hold, conflict, accept;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : gSlot
    localparam int BASE = SLOT_W * s;

    assign decOp[s]   = fBundle_q[BASE +: 3];
    assign decDest[s] = fBundle_q[BASE + DEST_LO +: RAW];
    assign decSrc1[s] = fBundle_q[BASE + S1_LO +: RAW];
    assign decSrc2[s] = fBundle_q[BASE + S2_LO +: RAW];
    assign decImm[s]  = XLEN'(fBundle_q[BASE + IMM_LO +: IMM_W]);
    assign decEn[s]   = fBundle_q[BASE + EN_BIT];

    vliw_slot_alu #(.XLEN(XLEN)) uAlu (
      .op_i     (dOp_q[s]),
      .s1_i     (rfRd[dSrc1_q[s]]),
      .s2_i     (rfRd[dSrc2_q[s]]),
      .imm_i    (dImm_q[s]),
      .result_o (aluResult[s]),
      .wr_en_o  (aluWe[s])
    );

    // Writes to a hard-wired r0 are dropped here so they also never count as conflicts.
    assign slotWe[s] = dEn_q[s] && aluWe[s] && !((R0_ZERO != 0) && (dDest_q[s] == '0));
    assign isMul[s]  = dEn_q[s] && (dOp_q[s] == OP_MUL);
  end

  assign hasMul = |isMul;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      rfRd[r] = ((R0_ZERO != 0) && (r == 0)) ? '0 : rf_q[r];
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = i + 1; j < NUM_SLOTS; j++) begin
        if (slotWe[i] && slotWe[j] && (dDest_q[i] == dDest_q[j])) conflict = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mulStart = 1'b0;
    retire   = 1'b0;
    case (state_q)
      X_RUN: begin
        if (dValid_q) begin
          if (hasMul && (MUL_LAT > 1)) begin
            mulStart = 1'b1;
            state_d  = MUL_WAIT;
            cnt_d    = CW'(MUL_LAT - 2);
          end else begin
            retire = 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        if (cnt_q == '0) begin
          retire  = 1'b1;
          state_d = X_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = X_RUN;
    endcase
  end

  // D is held from the edge that starts a MUL until the edge that retires it; F may
  // still absorb one bundle on the entry cycle if it happens to be empty.
  assign hold     = mulStart || ((state_q == MUL_WAIT) && !retire);
  assign in_ready = rstn && (state_q != MUL_WAIT) && !(hold && fValid_q);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= X_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fValid_q  <= 1'b0;
      fBundle_q <= '0;
      dValid_q  <= 1'b0;
      dEn_q     <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        dOp_q[s]   <= OP_NOP;
        dDest_q[s] <= '0;
        dSrc1_q[s] <= '0;
        dSrc2_q[s] <= '0;
        dImm_q[s]  <= '0;
      end
    end else begin
      if (accept) begin
        fValid_q  <= 1'b1;
        fBundle_q <= in_bundle;
      end else if (!hold) begin
        fValid_q <= 1'b0;
      end
      if (!hold) begin
        dValid_q <= fValid_q;
        dEn_q    <= decEn;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          dOp_q[s]   <= decOp[s];
          dDest_q[s] <= decDest[s];
          dSrc1_q[s] <= decSrc1[s];
          dSrc2_q[s] <= decSrc2[s];
          dImm_q[s]  <= decImm[s];
        end
      end
    end
  end

  // Ascending slot order makes the highest-index writer to a register win.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
    end else if (retire) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (slotWe[s]) rf_q[dDest_q[s]] <= aluResult[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      retiredCnt_q <= '0;
      wrConflict_q <= 1'b0;
    end else begin
      if (retire) retiredCnt_q <= retiredCnt_q + 32'd1;
      wrConflict_q <= retire && conflict;
    end
  end

  assign busy        = fValid_q || dValid_q;
  assign wr_conflict = wrConflict_q;
  assign retired_cnt = retiredCnt_q;
  assign dbg_data    = rfRd[dbg_addr];

endmodule

// File: tb/tb_vliw_core_param.sv
// Self-checking bench for vliw_core_param: directed scenarios plus random bundles,
// all compared against an architectural register-file model kept in the bench.
module tb_vliw_core_param;

  localparam int NS      = 4;
  localparam int MUL_LAT = 3;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] MUL  = 3'd1;
  localparam logic [2:0] ADDI = 3'd2;
  localparam logic [2:0] SUB  = 3'd3;
  localparam logic [2:0] MOV  = 3'd4;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_bundle;
  logic          busy;
  logic          wr_conflict;
  logic [31:0]   retired_cnt;
  logic [2:0]    dbg_addr;
  logic [31:0]   dbg_data;

  int compared = 0;
  int mismatched = 0;
  int conflictCycles = 0;

  logic [31:0] modelRf [8];
  int modelRetired;
  int modelConflicts;

  vliw_core_param #(
    .NUM_SLOTS (NS),
    .XLEN      (32),
    .NREGS     (8),
    .MUL_LAT   (MUL_LAT),
    .R0_ZERO   (1)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bundle   (in_bundle),
    .busy        (busy),
    .wr_conflict (wr_conflict),
    .retired_cnt (retired_cnt),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Every high cycle of wr_conflict stands for one conflicting bundle.
  always @(negedge clk) begin
    if (wr_conflict === 1'b1) conflictCycles++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkReg(input string tag, input int r, input logic [31:0] exp);
    dbg_addr = 3'(r);
    #1;
    checkOutput(tag, dbg_data, exp);
  endtask

  task automatic checkRegs(input string tag);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      checkOutput($sformatf("%s_r%0d", tag, r), dbg_data, modelRf[r]);
    end
  endtask

  function automatic logic [31:0] mkSlot(input logic en, input logic [2:0] op, input logic [2:0] d,
                                         input logic [2:0] a, input logic [2:0] b, input logic [18:0] imm);
    return {en, imm, b, a, d, op};
  endfunction

  task automatic modelReset();
    for (int r = 0; r < 8; r++) modelRf[r] = 32'd0;
    modelRetired = 0;
  endtask

  // Architectural effect of one bundle: all sources read before any write,
  // later slots overwrite earlier ones, r0 stays zero.
  task automatic modelApply(input logic [127:0] b);
    logic [31:0] old [8];
    logic [31:0] sl, a, c, imm, v;
    bit hit [8];
    bit conf;
    old = modelRf;
    conf = 1'b0;
    for (int r = 0; r < 8; r++) hit[r] = 1'b0;
    for (int s = 0; s < NS; s++) begin
      sl = b[32*s +: 32];
      if (sl[31] && (sl[2:0] != 3'd7) && (sl[5:3] != 3'd0)) begin
        a = old[sl[8:6]];
        c = old[sl[11:9]];
        imm = {13'd0, sl[30:12]};
        case (sl[2:0])
          3'd0: v = a + c;
          3'd1: v = a * c;
          3'd2: v = a + imm;
          3'd3: v = a - c;
          3'd4: v = imm;
          3'd5: v = a & c;
          default: v = a | c;
        endcase
        if (hit[sl[5:3]]) conf = 1'b1;
        hit[sl[5:3]] = 1'b1;
        modelRf[sl[5:3]] = v;
      end
    end
    modelRetired++;
    if (conf) modelConflicts++;
  endtask

  // Offer a bundle and hold it until the core takes it.
  task automatic applyStimulus(input logic [127:0] b);
    int w = 0;
    in_valid = 1'b1;
    in_bundle = b;
    while (in_ready !== 1'b1 && w < 30) begin
      step();
      w++;
    end
    checkOutput("accept_wait", 32'(w < 30), 32'd1);
    if (w < 30) begin
      step();
      modelApply(b);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    checkOutput("drain_wait", 32'(n < 40), 32'd1);
    step();
  endtask

  initial begin
    logic [127:0] b1, b2;
    int lowCnt, snap, base, confStart;

    rstn = 1'b0;
    in_valid = 1'b0;
    in_bundle = '0;
    dbg_addr = 3'd0;
    modelConflicts = 0;
    modelReset();

    $display("[TB] reset");
    step(); step(); step();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_retired", retired_cnt, 32'd0);
    checkOutput("rst_conflict", 32'(wr_conflict), 32'd0);
    checkRegs("rst");
    rstn = 1'b1;
    #1;
    checkOutput("ready_after_rst", 32'(in_ready), 32'd1);
    step();

    $display("[TB] MOV/MOV then dependent ADD");
    b1 = {32'd0, 32'd0, mkSlot(1'b1, MOV, 3'd2, 3'd0, 3'd0, 19'd7), mkSlot(1'b1, MOV, 3'd1, 3'd0, 3'd0, 19'd5)};
    b2 = {32'd0, 32'd0, 32'd0, mkSlot(1'b1, ADD, 3'd3, 3'd1, 3'd2, 19'd0)};
    in_valid = 1'b1;
    in_bundle = b1;
    checkOutput("t2_ready_b1", 32'(in_ready), 32'd1);
    step();
    modelApply(b1);
    in_bundle = b2;
    checkOutput("t2_ready_b2", 32'(in_ready), 32'd1);
    step();
    modelApply(b2);
    in_valid = 1'b0;
    checkReg("t2_r1_E1", 1, 32'd0);
    step();
    checkReg("t2_r1_E2", 1, 32'd5);
    checkReg("t2_r3_E2", 3, 32'd0);
    step();
    checkReg("t2_r3_E3", 3, 32'd12);
    checkOutput("t2_retired", retired_cnt, 32'd2);

    $display("[TB] MUL stall");
    b1 = {96'd0, mkSlot(1'b1, MUL, 3'd4, 3'd1, 3'd2, 19'd0)};
    in_valid = 1'b1;
    in_bundle = b1;
    checkOutput("t3_ready", 32'(in_ready), 32'd1);
    step();
    modelApply(b1);
    in_valid = 1'b0;
    lowCnt = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (in_ready !== 1'b1) lowCnt++;
      if (k == 3) checkReg("t3_r4_E3", 4, 32'd0);
      if (k == 4) checkReg("t3_r4_E4", 4, 32'd35);
    end
    checkOutput("t3_ready_low", 32'(lowCnt), 32'(MUL_LAT - 1));
    applyStimulus({96'd0, mkSlot(1'b1, ADDI, 3'd5, 3'd4, 3'd0, 19'd1)});
    drain();
    checkReg("t3_r5", 5, 32'd36);
    applyStimulus({96'd0, mkSlot(1'b1, MUL, 3'd6, 3'd4, 3'd2, 19'd0)});
    applyStimulus({96'd0, mkSlot(1'b1, ADDI, 3'd7, 3'd6, 3'd0, 19'd1)});
    drain();
    checkReg("t3_r7", 7, 32'd246);
    checkRegs("t3");

    $display("[TB] same-destination arbitration");
    snap = conflictCycles;
    applyStimulus({mkSlot(1'b1, MOV, 3'd6, 3'd0, 3'd0, 19'd9), 32'd0, 32'd0, mkSlot(1'b1, MOV, 3'd6, 3'd0, 3'd0, 19'd1)});
    drain();
    checkReg("t4_r6", 6, 32'd9);
    checkOutput("t4_pulse", 32'(conflictCycles - snap), 32'd1);
    snap = conflictCycles;
    applyStimulus({32'd0, mkSlot(1'b1, MOV, 3'd0, 3'd0, 3'd0, 19'd2), 32'd0, mkSlot(1'b1, MOV, 3'd0, 3'd0, 3'd0, 19'd1)});
    drain();
    checkOutput("t4_r0_noconf", 32'(conflictCycles - snap), 32'd0);

    $display("[TB] SUB wrap and r0");
    applyStimulus({64'd0, mkSlot(1'b1, MOV, 3'd0, 3'd0, 3'd0, 19'd3), mkSlot(1'b1, SUB, 3'd7, 3'd1, 3'd2, 19'd0)});
    drain();
    checkReg("t5_r7", 7, 32'hFFFF_FFFE);
    checkReg("t5_r0", 0, 32'd0);

    $display("[TB] bubble");
    base = modelRetired;
    b1 = {96'd0, mkSlot(1'b1, MOV, 3'd5, 3'd0, 3'd0, 19'd77)};
    b2 = {96'd0, mkSlot(1'b1, ADD, 3'd6, 3'd5, 3'd5, 19'd0)};
    in_valid = 1'b1;
    in_bundle = b1;
    checkOutput("t6_ready1", 32'(in_ready), 32'd1);
    step();
    modelApply(b1);
    in_valid = 1'b0;
    step();
    checkOutput("t6_busy_bubble", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_bundle = b2;
    checkOutput("t6_ready2", 32'(in_ready), 32'd1);
    step();
    modelApply(b2);
    in_valid = 1'b0;
    checkOutput("t6_busy_after", 32'(busy), 32'd1);
    drain();
    checkOutput("t6_retired", retired_cnt, 32'(base + 2));
    checkReg("t6_r6", 6, 32'd154);

    $display("[TB] random bundles");
    snap = conflictCycles;
    confStart = modelConflicts;
    for (int n = 0; n < 40; n++) begin
      for (int s = 0; s < NS; s++) begin
        b1[32*s +: 32] = mkSlot(1'($urandom_range(3) != 0), 3'($urandom_range(7)), 3'($urandom),
                                3'($urandom), 3'($urandom), 19'($urandom));
      end
      applyStimulus(b1);
      repeat ($urandom_range(2)) step();
    end
    drain();
    checkRegs("rnd");
    checkOutput("rnd_retired", retired_cnt, 32'(modelRetired));
    checkOutput("rnd_conflicts", 32'(conflictCycles - snap), 32'(modelConflicts - confStart));

    $display("[TB] reset during MUL wait");
    in_valid = 1'b1;
    in_bundle = {96'd0, mkSlot(1'b1, MUL, 3'd7, 3'd7, 3'd7, 19'd0)};
    checkOutput("t8_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    step();
    step();
    checkOutput("t8_in_mulwait", 32'(in_ready), 32'd0);
    rstn = 1'b0;
    step();
    modelReset();
    checkRegs("t8");
    checkOutput("t8_retired", retired_cnt, 32'd0);
    checkOutput("t8_busy", 32'(busy), 32'd0);
    checkOutput("t8_ready_rst", 32'(in_ready), 32'd0);
    rstn = 1'b1;
    step();
    applyStimulus({96'd0, mkSlot(1'b1, MOV, 3'd2, 3'd0, 3'd0, 19'd4)});
    applyStimulus({96'd0, mkSlot(1'b1, ADD, 3'd3, 3'd2, 3'd2, 19'd0)});
    drain();
    checkReg("t8_r3", 3, 32'd8);
    checkOutput("t8_retired_after", retired_cnt, 32'd2);
    checkRegs("t8_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
